// File: rtl/utf8_decoder.sv
// utf8_decoder: streaming UTF-8 byte decoder emitting codepoints, U+FFFD on malformed input,
// with optional leading-BOM removal and saturating output/error counters.
module utf8_decoder #(
    parameter bit STRIP_BOM = 1'b1
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [20:0] out_cp,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] cp_count,
    output logic [15:0] err_count
);
    typedef enum logic {LEAD, CONT} state_e;

    state_e      state_q, state_d;
    logic [1:0]  rem_q, rem_d;
    logic [20:0] acc_q, acc_d;
    logic [7:0]  lead_q, lead_d;
    logic        first_q, first_d;
    logic        bom_q, bom_d;
    logic        out_valid_q, out_valid_d;
    logic [20:0] out_cp_q, out_cp_d;
    logic        out_err_q, out_err_d;
    logic [15:0] cp_count_q, cp_count_d;
    logic [15:0] err_count_q, err_count_d;

    logic        space, is_cont, range_bad, emit, emit_err, drop, xfer;
    logic [20:0] emit_cp, acc_next;

    assign space    = !out_valid_q || out_ready;
    assign is_cont  = in_byte[7:6] == 2'b10;
    assign acc_next = {acc_q[14:0], in_byte[5:0]};
    // Only the first continuation byte is restricted, to reject overlongs, surrogates and >U+10FFFF.
    assign range_bad = first_q && ((lead_q == 8'hE0 && in_byte < 8'hA0) ||
                                   (lead_q == 8'hED && in_byte > 8'h9F) ||
                                   (lead_q == 8'hF0 && in_byte < 8'h90) ||
                                   (lead_q == 8'hF4 && in_byte > 8'h8F));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LEAD;
            rem_q       <= '0;
            acc_q       <= '0;
            lead_q      <= '0;
            first_q     <= 1'b0;
            bom_q       <= 1'b1;
            out_valid_q <= 1'b0;
            out_cp_q    <= '0;
            out_err_q   <= 1'b0;
            cp_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            lead_q      <= lead_d;
            first_q     <= first_d;
            bom_q       <= bom_d;
            out_valid_q <= out_valid_d;
            out_cp_q    <= out_cp_d;
            out_err_q   <= out_err_d;
            cp_count_q  <= cp_count_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        lead_d   = lead_q;
        first_d  = first_q;
        emit     = 1'b0;
        emit_err = 1'b0;
        emit_cp  = '0;
        if (space && in_valid) begin
            if (state_q == LEAD) begin
                lead_d  = in_byte;
                first_d = 1'b1;
                if (in_byte < 8'h80) begin
                    emit    = 1'b1;
                    emit_cp = {13'd0, in_byte};
                end else if (in_byte inside {[8'hC2:8'hDF]}) begin
                    state_d = CONT;
                    rem_d   = 2'd1;
                    acc_d   = {16'd0, in_byte[4:0]};
                end else if (in_byte inside {[8'hE0:8'hEF]}) begin
                    state_d = CONT;
                    rem_d   = 2'd2;
                    acc_d   = {17'd0, in_byte[3:0]};
                end else if (in_byte inside {[8'hF0:8'hF4]}) begin
                    state_d = CONT;
                    rem_d   = 2'd3;
                    acc_d   = {18'd0, in_byte[2:0]};
                end else begin
                    emit     = 1'b1;
                    emit_err = 1'b1;
                end
            end else if (!is_cont || range_bad) begin
                emit     = 1'b1;
                emit_err = 1'b1;
                state_d  = LEAD;
                rem_d    = '0;
                acc_d    = '0;
            end else if (rem_q == 2'd1) begin
                emit    = 1'b1;
                emit_cp = acc_next;
                state_d = LEAD;
                rem_d   = '0;
                acc_d   = '0;
                first_d = 1'b0;
            end else begin
                acc_d   = acc_next;
                rem_d   = rem_q - 2'd1;
                first_d = 1'b0;
            end
        end
    end

    always_comb begin
        in_ready    = space && !(in_valid && state_q == CONT && !is_cont);
        xfer        = out_valid_q && out_ready;
        drop        = STRIP_BOM && bom_q && emit && !emit_err && emit_cp == 21'h00FEFF;
        bom_d       = bom_q && !(emit && !emit_err);
        out_valid_d = (emit && !drop) ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_cp_d    = (emit && !drop) ? (emit_err ? 21'h00FFFD : emit_cp) : out_cp_q;
        out_err_d   = (emit && !drop) ? emit_err : out_err_q;
        cp_count_d  = (xfer && cp_count_q != 16'hFFFF) ? cp_count_q + 16'd1 : cp_count_q;
        err_count_d = (xfer && out_err_q && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
        out_valid   = out_valid_q;
        out_cp      = out_cp_q;
        out_err     = out_err_q;
        cp_count    = cp_count_q;
        err_count   = err_count_q;
    end
endmodule

// File: tb/tb_utf8_decoder.sv
// tb_utf8_decoder: table-driven byte streams plus hand-written latency, stall and reset sequences.
module tb_utf8_decoder;
    logic        clock = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] out_cp;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] cp_count;
    logic [15:0] err_count;

    int n_chk = 0;
    int n_fail = 0;
    logic [21:0] got[$];

    localparam logic [21:0] ERR = 22'h20FFFD;

    typedef struct {
        logic [31:0] b;
        int          nb;
        int          no;
        logic [21:0] o0, o1, o2;
        int          cc;
        int          ec;
    } vec_t;

    vec_t v[14];

    utf8_decoder #(.STRIP_BOM(1'b1)) dut (
        .clock(clock), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .out_cp(out_cp), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .cp_count(cp_count), .err_count(err_count)
    );

    always #5 clock = ~clock;

    // Inputs change just after posedge, so the negedge view is what the next edge transfers.
    always @(negedge clock)
        if (rst_n && out_valid && out_ready) got.push_back({out_err, out_cp});

    function automatic vec_t mk(input logic [31:0] b, input int nb, input int no,
                                input logic [21:0] o0, input logic [21:0] o1, input logic [21:0] o2,
                                input int cc, input int ec);
        vec_t r;
        r.b = b; r.nb = nb; r.no = no; r.o0 = o0; r.o1 = o1; r.o2 = o2; r.cc = cc; r.ec = ec;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        got.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int  n = 0;
        logic acc;
        in_byte = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: byte %h not accepted", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_byte = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_cp", out_cp, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_cp_count", cp_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_in_ready", in_ready, 1);

        v[0]  = mk(32'h41000000, 1, 1, 22'h000041, 0, 0, 1, 0);
        v[1]  = mk(32'hEFBBBF41, 4, 1, 22'h000041, 0, 0, 1, 0);
        v[2]  = mk(32'hE19ABB00, 3, 1, 22'h0016BB, 0, 0, 1, 0);
        v[3]  = mk(32'hE0808000, 3, 2, ERR, ERR, 0, 2, 2);
        v[4]  = mk(32'hC3410000, 2, 2, ERR, 22'h000041, 0, 2, 1);
        v[5]  = mk(32'hF4908080, 4, 3, ERR, ERR, ERR, 3, 3);
        v[6]  = mk(32'hF09F9880, 4, 1, 22'h01F600, 0, 0, 1, 0);
        v[7]  = mk(32'hC2A90000, 2, 1, 22'h0000A9, 0, 0, 1, 0);
        v[8]  = mk(32'hED9FBF00, 3, 1, 22'h00D7FF, 0, 0, 1, 0);
        v[9]  = mk(32'hEDA08000, 3, 2, ERR, ERR, 0, 2, 2);
        v[10] = mk(32'hF5000000, 1, 1, ERR, 0, 0, 1, 1);
        v[11] = mk(32'hC0000000, 1, 1, ERR, 0, 0, 1, 1);
        v[12] = mk(32'hF48FBFBF, 4, 1, 22'h10FFFF, 0, 0, 1, 0);
        v[13] = mk(32'hEFBBBFEF, 4, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            do_reset();
            for (int j = 0; j < v[i].nb; j++) send(v[i].b[31-8*j -: 8]);
            repeat (4) @(posedge clock);
            #1;
            chk($sformatf("v%0d_nout", i), got.size(), v[i].no);
            for (int k = 0; k < v[i].no && k < got.size(); k++)
                chk($sformatf("v%0d_out%0d", i, k), got[k], (k == 0) ? v[i].o0 : (k == 1) ? v[i].o1 : v[i].o2);
            chk($sformatf("v%0d_cp_count", i), cp_count, v[i].cc);
            chk($sformatf("v%0d_err_count", i), err_count, v[i].ec);
        end

        // Second U+FEFF after the stripped first one must pass through.
        send(8'hBB);
        send(8'hBF);
        repeat (3) @(posedge clock);
        #1;
        chk("bom2_nout", got.size(), 1);
        if (got.size() > 0) chk("bom2_out", got[0], 22'h00FEFF);

        do_reset();
        send(8'hE1);
        send(8'h9A);
        chk("lat_before", out_valid, 0);
        send(8'hBB);
        chk("lat_valid", out_valid, 1);
        chk("lat_cp", out_cp, 21'h0016BB);

        do_reset();
        send(8'hC3);
        in_byte = 8'h41;
        in_valid = 1'b1;
        #1;
        chk("c341_stall", in_ready, 0);
        @(posedge clock);
        #1;
        chk("c341_err", {out_err, out_cp}, ERR);
        chk("c341_ready", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("c341_cp", {out_err, out_cp}, 22'h000041);

        do_reset();
        out_ready = 1'b0;
        send(8'h41);
        in_byte = 8'h42;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            chk($sformatf("bp_in_ready%0d", c), in_ready, 0);
            chk($sformatf("bp_hold%0d", c), {out_valid, out_cp}, 22'h200041);
        end
        out_ready = 1'b1;
        send(8'h42);
        send(8'h43);
        repeat (3) @(posedge clock);
        #1;
        chk("bp_nout", got.size(), 3);
        for (int k = 0; k < 3 && k < got.size(); k++)
            chk($sformatf("bp_out%0d", k), got[k], 22'h41 + k);
        chk("bp_cp_count", cp_count, 3);

        do_reset();
        send(8'hE1);
        send(8'h9A);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        chk("mid_post_in_ready", in_ready, 1);
        repeat (3) @(posedge clock);
        #1;
        chk("mid_nout", got.size(), 0);
        chk("mid_cp_count", cp_count, 0);
        send(8'h41);
        repeat (3) @(posedge clock);
        #1;
        chk("mid_after_nout", got.size(), 1);
        if (got.size() > 0) chk("mid_after_cp", got[0], 22'h000041);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
